// File: rtl/eth_fcs_pkg.sv
// Shared constants, state encoding and bit-serial CRC-32 step for the FCS engine.
// Purely declarative; no clocked logic and no flow control here.
package eth_fcs_pkg;

    localparam logic [31:0] CRC32_POLY    = 32'hEDB88320;
    localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
    localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB20E3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        FCS  = 2'd2
    } fcs_state_t;

    // Advances the reflected CRC by nbits wire bits taken LSB-first from data.
    function automatic logic [31:0] crc32_step(input logic [31:0] crc,
                                               input logic [31:0] data,
                                               input int          nbits);
        logic [31:0] c;
        logic        fb;
        c = crc;
        for (int i = 0; i < 32; i++) begin
            if (i < nbits) begin
                fb = c[0] ^ data[i];
                c  = (c >> 1) ^ (fb ? CRC32_POLY : 32'h0);
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/eth_crc32_step.sv
// Combinational CRC-32 update over one DATA_W-bit beat (LSB = first wire bit).
// Zero latency; no flow control.
module eth_crc32_step
    import eth_fcs_pkg::*;
#(
    parameter int DATA_W = 2
) (
    input  logic [31:0]       crc_in,
    input  logic [DATA_W-1:0] data,
    output logic [31:0]       crc_out
);

    logic [31:0] data_pad;

    assign data_pad = 32'(data);
    assign crc_out  = crc32_step(crc_in, data_pad, DATA_W);

endmodule

// File: rtl/eth_fcs_engine.sv
// Ethernet FCS generate/check on a DATA_W-bit stream; one-deep registered output, 1-cycle latency.
// s_ready follows the output register and drops while GEN-mode FCS beats are emitted.
module eth_fcs_engine
    import eth_fcs_pkg::*;
#(
    parameter int DATA_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mode_check,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_valid,
    input  logic              s_last,
    output logic              s_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    output logic              m_last,
    input  logic              m_ready,
    output logic [31:0]       fcs_value,
    output logic              fcs_done,
    output logic              fcs_ok
);

    localparam int                FCS_BEATS = 32 / DATA_W;
    localparam int                CNT_W     = $clog2(FCS_BEATS);
    localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(FCS_BEATS - 1);

    generate
        if (DATA_W != 1 && DATA_W != 2 && DATA_W != 4 && DATA_W != 8) begin : g_bad_width
            $error("eth_fcs_engine: DATA_W must be 1, 2, 4 or 8");
        end
    endgenerate

    fcs_state_t        state_q;
    fcs_state_t        state_d;
    logic              mode_q;
    logic              mode_eff;
    logic              out_free;
    logic              acc;
    logic              fcs_load;
    logic              fcs_final;
    logic [31:0]       crc_q;
    logic [31:0]       crc_next;
    logic [31:0]       fcs_sr;
    logic [CNT_W-1:0]  beat_cnt;

    eth_crc32_step #(.DATA_W(DATA_W)) u_step (
        .crc_in  (crc_q),
        .data    (s_data),
        .crc_out (crc_next)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (acc) begin
                    if (s_last) begin
                        state_d = mode_check ? IDLE : FCS;
                    end else begin
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                if (acc && s_last) begin
                    state_d = mode_q ? IDLE : FCS;
                end
            end
            FCS: begin
                if (fcs_final) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // The mode of an open frame is frozen; only a frame's first beat looks at mode_check.
    always_comb begin
        out_free  = !m_valid || m_ready;
        s_ready   = (state_q != FCS) && out_free;
        acc       = s_valid && s_ready;
        fcs_load  = (state_q == FCS) && out_free;
        fcs_final = fcs_load && (beat_cnt == LAST_BEAT);
        mode_eff  = (state_q == IDLE) ? mode_check : mode_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            crc_q     <= CRC32_INIT;
            mode_q    <= 1'b0;
            fcs_sr    <= '0;
            beat_cnt  <= '0;
            m_data    <= '0;
            m_valid   <= 1'b0;
            m_last    <= 1'b0;
            fcs_value <= '0;
            fcs_done  <= 1'b0;
            fcs_ok    <= 1'b0;
        end else begin
            fcs_done <= 1'b0;
            if (acc) begin
                m_data  <= s_data;
                m_valid <= 1'b1;
                m_last  <= s_last && mode_eff;
                if (state_q == IDLE) begin
                    mode_q <= mode_check;
                end
                if (s_last) begin
                    crc_q     <= CRC32_INIT;
                    fcs_value <= ~crc_next;
                    if (mode_eff) begin
                        fcs_ok   <= (crc_next == CRC32_RESIDUE);
                        fcs_done <= 1'b1;
                    end else begin
                        fcs_sr   <= ~crc_next;
                        beat_cnt <= '0;
                    end
                end else begin
                    crc_q <= crc_next;
                end
            end else if (fcs_load) begin
                // FCS leaves least-significant beat first, matching wire order.
                m_data   <= fcs_sr[DATA_W-1:0];
                m_valid  <= 1'b1;
                m_last   <= fcs_final;
                fcs_sr   <= fcs_sr >> DATA_W;
                beat_cnt <= beat_cnt + 1'b1;
                if (fcs_final) begin
                    fcs_done <= 1'b1;
                    fcs_ok   <= 1'b1;
                end
            end else if (m_ready) begin
                m_valid <= 1'b0;
                m_last  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_eth_fcs_engine.sv
// Directed checks of eth_fcs_engine at DATA_W=8 and DATA_W=2 against hand-computed FCS values.
module tb_eth_fcs_engine;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // DATA_W = 8 instance
    logic        mode8, s_valid8, s_last8, s_ready8, m_valid8, m_last8, m_ready8, fcs_done8, fcs_ok8;
    logic [7:0]  s_data8, m_data8;
    logic [31:0] fcs_value8;
    // DATA_W = 2 instance
    logic        mode2, s_valid2, s_last2, s_ready2, m_valid2, m_last2, m_ready2, fcs_done2, fcs_ok2;
    logic [1:0]  s_data2, m_data2;
    logic [31:0] fcs_value2;

    eth_fcs_engine #(.DATA_W(8)) u_dut8 (
        .clk(clk), .rst(rst), .mode_check(mode8),
        .s_data(s_data8), .s_valid(s_valid8), .s_last(s_last8), .s_ready(s_ready8),
        .m_data(m_data8), .m_valid(m_valid8), .m_last(m_last8), .m_ready(m_ready8),
        .fcs_value(fcs_value8), .fcs_done(fcs_done8), .fcs_ok(fcs_ok8)
    );

    eth_fcs_engine #(.DATA_W(2)) u_dut2 (
        .clk(clk), .rst(rst), .mode_check(mode2),
        .s_data(s_data2), .s_valid(s_valid2), .s_last(s_last2), .s_ready(s_ready2),
        .m_data(m_data2), .m_valid(m_valid2), .m_last(m_last2), .m_ready(m_ready2),
        .fcs_value(fcs_value2), .fcs_done(fcs_done2), .fcs_ok(fcs_ok2)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, expv);
        end
    endtask

    logic [7:0] tx8  [16];
    logic [7:0] exp8 [24];
    bit         bp_en = 1'b0;

    // Output monitors: every handshaken beat, every fcs_done pulse.
    logic [7:0]  out8_q [$];
    bit          last8_q[$];
    int          cyc8_q [$];
    logic [1:0]  out2_q [$];
    bit          last2_q[$];
    int          cyc = 0;
    int          done8_cnt = 0;
    int          done2_cnt = 0;
    logic [31:0] done8_val = '0;
    logic [31:0] done2_val = '0;
    logic        done8_ok  = 1'b0;
    logic        done2_ok  = 1'b0;
    int          rdy_viol  = 0;
    bit          fcs_win   = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (m_valid8 && m_ready8) begin
            out8_q.push_back(m_data8);
            last8_q.push_back(m_last8);
            cyc8_q.push_back(cyc);
        end
        if (fcs_done8) begin
            done8_cnt++;
            done8_val = fcs_value8;
            done8_ok  = fcs_ok8;
        end
        if (fcs_win && s_ready8 && !fcs_done8) rdy_viol++;
        if (fcs_done8) fcs_win = 1'b0;
        if (s_valid8 && s_ready8 && s_last8 && !u_dut8.mode_eff) fcs_win = 1'b1;
        if (m_valid2 && m_ready2) begin
            out2_q.push_back(m_data2);
            last2_q.push_back(m_last2);
        end
        if (fcs_done2) begin
            done2_cnt++;
            done2_val = fcs_value2;
            done2_ok  = fcs_ok2;
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            m_ready8 = bp_en ? ~m_ready8 : 1'b1;
        end
    end

    task automatic wait_acc(input bit wide, input string tag);
        int t;
        bit ok;
        t  = 0;
        ok = 1'b0;
        while (!ok && t < 200) begin
            @(negedge clk);
            ok = wide ? s_ready8 : s_ready2;
            t++;
        end
        check_eq(tag, 32'(ok), 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic send8(input int start, input int n, input logic mode, input bit gaps, input bit last_en);
        for (int i = 0; i < n; i++) begin
            if (gaps && (i % 3 == 2)) begin
                s_valid8 = 1'b0;
                repeat (2) @(posedge clk);
                #1;
            end
            mode8    = (i == 0) ? mode : ~mode;
            s_data8  = tx8[start + i];
            s_last8  = last_en && (i == n - 1);
            s_valid8 = 1'b1;
            wait_acc(1'b1, "accept8");
        end
        s_valid8 = 1'b0;
        s_last8  = 1'b0;
    endtask

    task automatic send2(input int nbytes);
        for (int b = 0; b < nbytes; b++) begin
            for (int k = 0; k < 4; k++) begin
                mode2    = 1'b0;
                s_data2  = tx8[b][2*k +: 2];
                s_last2  = (b == nbytes - 1) && (k == 3);
                s_valid2 = 1'b1;
                wait_acc(1'b0, "accept2");
            end
        end
        s_valid2 = 1'b0;
        s_last2  = 1'b0;
    endtask

    task automatic wait_out8(input int target);
        int t;
        t = 0;
        while (out8_q.size() < target && t < 2000) begin
            @(negedge clk);
            t++;
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic check_beats8(input string tag, input int base, input int n, input int la, input int lb);
        check_eq({tag, "_count"}, 32'(out8_q.size() - base), 32'(n));
        for (int i = 0; i < n && base + i < out8_q.size(); i++) begin
            check_eq($sformatf("%s_data%0d", tag, i), 32'(out8_q[base + i]), 32'(exp8[i]));
            check_eq($sformatf("%s_last%0d", tag, i), 32'(last8_q[base + i]), 32'((i == la) || (i == lb)));
        end
    endtask

    task automatic run_gen8(input string tag, input bit gaps);
        int base, d0, v0;
        base = out8_q.size();
        d0   = done8_cnt;
        v0   = rdy_viol;
        for (int i = 0; i < 13; i++) exp8[i] = tx8[i];
        send8(0, 9, 1'b0, gaps, 1'b1);
        wait_out8(base + 13);
        check_beats8(tag, base, 13, 12, 12);
        check_eq({tag, "_done_cnt"}, 32'(done8_cnt - d0), 32'd1);
        check_eq({tag, "_fcs_value"}, done8_val, 32'hCBF43926);
        check_eq({tag, "_fcs_ok"}, 32'(done8_ok), 32'd1);
        check_eq({tag, "_ready_in_fcs"}, 32'(rdy_viol - v0), 32'd0);
    endtask

    initial begin
        int base, d0;
        logic [31:0] fcs_ref;

        #500000;
        $display("FAIL watchdog: simulation did not finish, cyc=%0d expected=<done>", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int base, d0;
        logic [31:0] fcs_ref;

        tx8 = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
                8'h26, 8'h39, 8'hF4, 8'hCB, 8'h00, 8'h00, 8'h00};
        rst = 1'b1;
        mode8 = 1'b0; s_data8 = '0; s_valid8 = 1'b0; s_last8 = 1'b0;
        mode2 = 1'b0; s_data2 = '0; s_valid2 = 1'b0; s_last2 = 1'b0;
        m_ready2 = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // Reset state
        check_eq("rst_m_valid", 32'(m_valid8), 32'd0);
        check_eq("rst_m_last", 32'(m_last8), 32'd0);
        check_eq("rst_m_data", 32'(m_data8), 32'd0);
        check_eq("rst_s_ready", 32'(s_ready8), 32'd1);
        check_eq("rst_fcs_done", 32'(fcs_done8), 32'd0);
        check_eq("rst_fcs_ok", 32'(fcs_ok8), 32'd0);
        check_eq("rst_fcs_value", fcs_value8, 32'h0);
        check_eq("rst_crc_q", u_dut8.crc_q, 32'hFFFFFFFF);
        check_eq("rst2_m_valid", 32'(m_valid2), 32'd0);
        check_eq("rst2_s_ready", 32'(s_ready2), 32'd1);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // 1: GEN, 8-bit
        run_gen8("gen8", 1'b0);

        // 2: GEN, 2-bit
        d0      = done2_cnt;
        fcs_ref = 32'hCBF43926;
        send2(9);
        for (int t = 0; t < 200 && out2_q.size() < 52; t++) @(negedge clk);
        repeat (3) @(posedge clk);
        #1;
        check_eq("gen2_count", 32'(out2_q.size()), 32'd52);
        for (int i = 0; i < 52 && i < out2_q.size(); i++) begin
            if (i < 36) check_eq($sformatf("gen2_data%0d", i), 32'(out2_q[i]), 32'(tx8[i / 4][2*(i % 4) +: 2]));
            else        check_eq($sformatf("gen2_fcs%0d", i - 36), 32'(out2_q[i]), 32'(fcs_ref[2*(i - 36) +: 2]));
            check_eq($sformatf("gen2_last%0d", i), 32'(last2_q[i]), 32'(i == 51));
        end
        check_eq("gen2_fcs_dibit0", 32'(out2_q[36]), 32'd2);
        check_eq("gen2_fcs_dibit1", 32'(out2_q[37]), 32'd1);
        check_eq("gen2_fcs_dibit2", 32'(out2_q[38]), 32'd2);
        check_eq("gen2_fcs_dibit3", 32'(out2_q[39]), 32'd0);
        check_eq("gen2_done_cnt", 32'(done2_cnt - d0), 32'd1);
        check_eq("gen2_fcs_value", done2_val, 32'hCBF43926);
        check_eq("gen2_fcs_ok", 32'(done2_ok), 32'd1);

        // 3: CHECK, good FCS then corrupted FCS
        base = out8_q.size();
        d0   = done8_cnt;
        for (int i = 0; i < 13; i++) exp8[i] = tx8[i];
        send8(0, 13, 1'b1, 1'b0, 1'b1);
        wait_out8(base + 13);
        check_beats8("chk_good", base, 13, 12, 12);
        check_eq("chk_good_done_cnt", 32'(done8_cnt - d0), 32'd1);
        check_eq("chk_good_fcs_ok", 32'(done8_ok), 32'd1);
        check_eq("chk_good_fcs_value", done8_val, 32'h2144DF1C);

        base = out8_q.size();
        d0   = done8_cnt;
        tx8[12]  = 8'hCA;
        exp8[12] = 8'hCA;
        send8(0, 13, 1'b1, 1'b0, 1'b1);
        wait_out8(base + 13);
        tx8[12] = 8'hCB;
        check_beats8("chk_bad", base, 13, 12, 12);
        check_eq("chk_bad_done_cnt", 32'(done8_cnt - d0), 32'd1);
        check_eq("chk_bad_fcs_ok", 32'(done8_ok), 32'd0);

        // 4: backpressure, input gaps, mode_check toggling mid-frame
        bp_en = 1'b1;
        run_gen8("bp8", 1'b1);
        bp_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // 5: back-to-back GEN frames, second is a single 0x00 byte
        base = out8_q.size();
        d0   = done8_cnt;
        for (int i = 0; i < 13; i++) exp8[i] = tx8[i];
        exp8[13] = 8'h00; exp8[14] = 8'h8D; exp8[15] = 8'hEF; exp8[16] = 8'h02; exp8[17] = 8'hD2;
        send8(0, 9, 1'b0, 1'b0, 1'b1);
        send8(13, 1, 1'b0, 1'b0, 1'b1);
        wait_out8(base + 18);
        check_beats8("b2b", base, 18, 12, 17);
        check_eq("b2b_done_cnt", 32'(done8_cnt - d0), 32'd2);
        check_eq("b2b_fcs_value", done8_val, 32'hD202EF8D);
        if (out8_q.size() >= base + 18)
            check_eq("b2b_span", 32'(cyc8_q[base + 17] - cyc8_q[base]), 32'd17);

        // 6: reset mid-frame, then a clean frame
        d0 = done8_cnt;
        send8(0, 4, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        check_eq("abort_m_valid", 32'(m_valid8), 32'd0);
        check_eq("abort_fcs_done", 32'(fcs_done8), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("abort_done_cnt", 32'(done8_cnt - d0), 32'd0);
        check_eq("abort_fcs_value", fcs_value8, 32'h0);
        run_gen8("post_rst", 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/eth_fcs_engine.md
Name: eth_fcs_engine

Overview:
Parametrised Ethernet FCS (CRC-32, reflected poly 0xEDB88320) engine for an AXI-Stream-style byte/dibit stream of DATA_W bits per beat. In GEN mode it passes the frame through and appends the 4-byte FCS as extra beats. In CHECK mode it passes the frame through unchanged and reports whether the trailing FCS is correct. It sits between the MAC framer and the RMII/GMII PHY adaptor.

Parameters:
DATA_W, 2, bits per beat, LSB = first bit on the wire; legal values 1, 2, 4, 8 (elaboration error otherwise).
FCS_BEATS, 32/DATA_W, derived localparam: number of FCS beats appended in GEN mode.

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
mode_check  in  1  0 = GEN (append FCS), 1 = CHECK; sampled on the first accepted beat of each frame
s_data  in  DATA_W  input beat
s_valid  in  1  input beat valid
s_last  in  1  final beat of frame (in CHECK mode this includes the received FCS)
s_ready  out  1  input accepted when s_valid & s_ready
m_data  out  DATA_W  output beat (registered)
m_valid  out  1  output valid
m_last  out  1  final output beat of frame
m_ready  in  1  downstream accept
fcs_value  out  32  last computed FCS (complemented CRC, wire byte order LSB-first), held until the next frame ends
fcs_done  out  1  one-cycle pulse at frame end
fcs_ok  out  1  CHECK result, valid while fcs_done = 1; forced 1 in GEN mode

Behaviour:
- Reset: state IDLE; crc_q = 0xFFFFFFFF; m_valid = 0, m_last = 0, m_data = 0, fcs_done = 0, fcs_ok = 0, fcs_value = 0, s_ready = 1.
- Output register: one-deep. s_ready = (state != FCS) & (!m_valid | m_ready). Accepted input is presented on m_* in the next cycle; latency is 1 cycle. m_* hold while m_valid & !m_ready.
- CRC update on each accepted input beat: crc_q <= crc_step(crc_q, s_data). For each bit i = 0..DATA_W-1: fb = crc[0] ^ d[i]; crc = (crc >> 1) ^ (fb ? 0xEDB88320 : 0).
- States:
  - IDLE: no frame is open. The first accepted beat latches mode_check into mode_q and goes to DATA, or handles the last-beat case if s_last = 1.
  - DATA: frame is open and beats pass through.
  - FCS: GEN mode only; FCS beats are being emitted.
- Last beat accepted, GEN mode:
  - m_last is NOT set on this beat.
  - fcs_sr <= ~crc_step(crc_q, s_data); fcs_value gets the same value.
  - crc_q <= 0xFFFFFFFF; beat_cnt <= 0; go to FCS.
- FCS state:
  - When the output register is free, load m_data = fcs_sr[DATA_W-1:0], then shift fcs_sr right by DATA_W and increment beat_cnt.
  - On beat FCS_BEATS-1, set m_last = 1 and pulse fcs_done with fcs_ok = 1 when that beat is loaded, then go to IDLE.
- Last beat accepted, CHECK mode:
  - Beat is passed through with m_last = 1.
  - next = crc_step(crc_q, s_data); fcs_ok <= (next == 0xDEBB20E3) (residue); fcs_value <= ~next.
  - fcs_done pulses the next cycle; crc_q <= 0xFFFFFFFF; go to IDLE.
- Single-beat frames (s_last on first beat) are legal in both modes.
- Back-to-back frames: the next frame's first beat may be accepted in the cycle after the GEN final FCS beat is loaded, or directly after a CHECK last beat. No idle gap is required.
- s_valid low mid-frame: CRC and state hold. mode_check changes mid-frame are ignored.
- Async reset mid-frame: immediate return to reset values; the partial frame is discarded, with no m_last and no fcs_done.

Decomposition:
- Package eth_fcs_pkg:
  - CRC32_POLY = 32'hEDB88320, CRC32_INIT = 32'hFFFFFFFF, CRC32_RESIDUE = 32'hDEBB20E3.
  - Enum fcs_state_t {IDLE, DATA, FCS}.
  - Function crc32_step #(width generic via loop over a 32-bit-padded input + count argument).
- Sub-module eth_crc32_step (purely combinational, parameter DATA_W) wraps the function so it can be unit-tested stand-alone against the existing 2-bit generator equations.

Test Plan:
1. GEN, DATA_W=8: ASCII "123456789" (0x31..0x39), m_ready = 1 -> 13 output beats: the 9 input bytes then 0x26, 0x39, 0xF4, 0xCB; m_last on 0xCB; fcs_value = 0xCBF43926; fcs_done pulse with fcs_ok = 1.
2. GEN, DATA_W=2: same string as dibits LSB-first -> 36 data beats + 16 FCS beats; first FCS dibits 2, 1, 2, 0; fcs_value = 0xCBF43926.
3. CHECK, DATA_W=8: "123456789" followed by 26 39 F4 CB with s_last on 0xCB -> 13 beats passed through, m_last on the 13th; fcs_ok = 1. Repeat with the last byte 0xCA -> fcs_ok = 0.
4. Backpressure: test 1 with m_ready toggling 1010... and s_valid gaps -> identical output sequence; no beat duplicated or dropped; s_ready = 0 for all FCS beats.
5. Back-to-back: GEN "123456789" immediately followed by a single-beat frame 0x00 -> second fcs_value = 0xD202EF8D; no gap cycles beyond the FCS beats.
6. Reset mid-frame: assert rst after 4 bytes, release, then run test 1 -> no fcs_done for the aborted frame; test 1 results are exact.
